// File: rtl/stone_renderer.sv
`timescale 1ns/1ps
// stone_renderer
//   Per-frame reader of the shared stone RAM. A start pulse begins a render pass. The
//   block takes RAM read ownership, reads stones 0..quantity-1 and decodes each 32-bit
//   word. Every visible stone is drawn as a solid SPRITE_W x SPRITE_H block, one pixel
//   per cycle, on the VGA adapter plot interface.
//
// Ports
//   clock           system clock; all state changes on the rising edge
//   resetn          asynchronous active-low reset
//   start           pulse that begins a render pass (ignored unless idle)
//   quantity        number of stones in RAM, latched when start is accepted
//   stone_data      RAM read data: [31:23]=x [18:11]=y [3:2]=type [1]=visible [0]=moving
//   draw_stone_flag high for the whole pass; the RAM address mux then selects draw_index
//   draw_index      RAM address of the stone being read
//   vga_x, vga_y    pixel coordinate
//   vga_colour      pixel colour
//   plot            pixel write strobe, qualifies vga_x/vga_y/vga_colour
//   done            one-cycle pulse at the end of a pass
//   debug_state     current FSM state, for checkers and debug
//
// Handshake: start is a request. It is sampled only in S_IDLE, and any start seen while
// a pass runs (including the S_DONE cycle) is dropped. The request is complete when
// done pulses for one cycle. A pass with quantity==0 reads nothing and pulses done.
// The pixel interface has no backpressure: a pixel is written on every cycle where
// plot=1.
module stone_renderer #(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240,
    parameter int         READ_LAT    = 2,
    parameter logic [2:0] COL_STONE   = 3'b111,
    parameter logic [2:0] COL_GOLD    = 3'b110,
    parameter logic [2:0] COL_DIAMOND = 3'b011
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] stone_data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic        done,
    output logic [2:0]  debug_state
);

    localparam int PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int WCW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
    // The address cycle (S_ADDR) counts as the first latency cycle. S_WAIT covers the
    // remaining READ_LAT-1 cycles, so it ends when wait_cnt reaches READ_LAT-2.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3,
        S_DRAW  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t         state, state_next;
    logic [3:0]     qty_lat;
    logic [WCW-1:0] wait_cnt;
    logic [8:0]     stone_x;
    logic [7:0]     stone_y;
    logic [1:0]     stone_type;
    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic [9:0]     x_sum;
    logic [8:0]     y_sum;
    logic           in_view;
    logic           px_last;
    logic           py_last;
    logic           last_stone;
    logic [2:0]     colour;
    logic           unused_bits;

    // Address bits, padding fields and the moving flag have no effect on rendering.
    assign unused_bits = ^{stone_data[22:19], stone_data[10:4], stone_data[0]};

    assign debug_state = state;

    // The sums are one bit wider than the coordinates, so a sprite that runs past the
    // edge of the screen is clipped and does not wrap back to the left or top.
    assign x_sum      = {1'b0, stone_x} + 10'(px);
    assign y_sum      = {1'b0, stone_y} + 9'(py);
    assign in_view    = (x_sum < 10'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));
    assign px_last    = (px == PXW'(SPRITE_W - 1));
    assign py_last    = (py == PYW'(SPRITE_H - 1));
    assign last_stone = (draw_index == (qty_lat - 4'd1));

    always_comb begin
        colour = COL_DIAMOND;
        case (stone_type)
            2'b00:   colour = COL_STONE;
            2'b01:   colour = COL_GOLD;
            default: colour = COL_DIAMOND;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (quantity == 4'd0) ? S_DONE : S_ADDR;
            S_ADDR:  state_next = S_WAIT;
            S_WAIT:  if (wait_cnt >= WAIT_LAST) state_next = S_LATCH;
            S_LATCH: state_next = stone_data[1] ? S_DRAW : S_NEXT;
            S_DRAW:  if (px_last && py_last) state_next = S_NEXT;
            S_NEXT:  state_next = last_stone ? S_DONE : S_ADDR;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. plot and done default to 0 on every cycle.
    // The vga_* outputs change only when a pixel is actually plotted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            qty_lat         <= '0;
            draw_index      <= '0;
            draw_stone_flag <= 1'b0;
            wait_cnt        <= '0;
            stone_x         <= '0;
            stone_y         <= '0;
            stone_type      <= '0;
            px              <= '0;
            py              <= '0;
            vga_x           <= '0;
            vga_y           <= '0;
            vga_colour      <= '0;
            plot            <= 1'b0;
            done            <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        qty_lat    <= quantity;
                        draw_index <= '0;
                    end
                end
                S_ADDR: begin
                    draw_stone_flag <= 1'b1;
                    wait_cnt        <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WCW'(1);
                end
                S_LATCH: begin
                    stone_x    <= stone_data[31:23];
                    stone_y    <= stone_data[18:11];
                    stone_type <= stone_data[3:2];
                    px         <= '0;
                    py         <= '0;
                end
                S_DRAW: begin
                    if (in_view) begin
                        plot       <= 1'b1;
                        vga_x      <= x_sum[8:0];
                        vga_y      <= y_sum[7:0];
                        vga_colour <= colour;
                    end
                    // The counters advance even for clipped pixels, so every
                    // visible stone takes exactly SPRITE_W*SPRITE_H cycles.
                    if (px_last) begin
                        px <= '0;
                        py <= py + PYW'(1);
                    end else begin
                        px <= px + PXW'(1);
                    end
                end
                S_NEXT: begin
                    if (!last_stone) draw_index <= draw_index + 4'd1;
                end
                S_DONE: begin
                    done            <= 1'b1;
                    draw_stone_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
